fir_controller: RTL

// Sequencing FSM for the FIR datapath. Per accepted input sample it shifts the sample delay

---
 rtl/fir_controller.sv | 112 +++++++++++
 1 files changed

// File: rtl/fir_controller.sv
// Sequencing FSM for the FIR datapath: shifts the delay line, clears the accumulator,
// steps the MAC through every tap, then flags the result. Overrun/overflow abort into ERR.
module fir_controller #(
  parameter  int NUM_TAPS = 4,
  localparam int TAP_W    = $clog2(NUM_TAPS)
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             data_ready_i,
  input  logic             coeff_ready_i,
  input  logic             overflow_i,
  output logic             shift_en_o,
  output logic             acc_clear_o,
  output logic             acc_en_o,
  output logic [TAP_W-1:0] tap_sel_o,
  output logic             fir_out_valid_o,
  output logic             cnt_up_o,
  output logic             clear_o,
  output logic             modwait_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ZERO = 3'd2,
    MAC  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [TAP_W-1:0] LastTap = TAP_W'(NUM_TAPS - 1);

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             recover_q, recover_d;

  logic             shift_en_q, acc_clear_q, acc_en_q, fir_out_valid_q;
  logic             cnt_up_q, clear_q, modwait_q, err_q;
  logic [TAP_W-1:0] tap_sel_q;

  // A strobe while busy, or an overflow while accumulating, abandons the run.
  always_comb begin
    state_d   = state_q;
    tap_d     = '0;
    recover_d = recover_q;
    case (state_q)
      IDLE: if (data_ready_i && coeff_ready_i) state_d = LOAD;
      LOAD: begin
        recover_d = 1'b0;
        state_d   = data_ready_i ? ERR : ZERO;
      end
      ZERO: state_d = data_ready_i ? ERR : MAC;
      MAC: begin
        if (data_ready_i || overflow_i) begin
          state_d = ERR;
        end else if (tap_q == LastTap) begin
          state_d = DONE;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      DONE: state_d = data_ready_i ? ERR : IDLE;
      ERR:  if (data_ready_i && coeff_ready_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (state_d == ERR) recover_d = 1'b1;
  end

  // Outputs are registered from the next state so each one lines up with its state cycle.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q         <= IDLE;
      tap_q           <= '0;
      recover_q       <= 1'b0;
      shift_en_q      <= 1'b0;
      acc_clear_q     <= 1'b0;
      acc_en_q        <= 1'b0;
      tap_sel_q       <= '0;
      fir_out_valid_q <= 1'b0;
      cnt_up_q        <= 1'b0;
      clear_q         <= 1'b0;
      modwait_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      tap_q           <= tap_d;
      recover_q       <= recover_d;
      shift_en_q      <= (state_d == LOAD);
      clear_q         <= (state_d == LOAD) && recover_q;
      acc_clear_q     <= (state_d == ZERO);
      acc_en_q        <= (state_d == MAC);
      tap_sel_q       <= (state_d == MAC) ? tap_d : '0;
      fir_out_valid_q <= (state_d == DONE);
      cnt_up_q        <= (state_d == DONE);
      modwait_q       <= (state_d == LOAD) || (state_d == ZERO) ||
                         (state_d == MAC)  || (state_d == DONE);
      err_q           <= (state_d == ERR);
    end
  end

  assign shift_en_o      = shift_en_q;
  assign acc_clear_o     = acc_clear_q;
  assign acc_en_o        = acc_en_q;
  assign tap_sel_o       = tap_sel_q;
  assign fir_out_valid_o = fir_out_valid_q;
  assign cnt_up_o        = cnt_up_q;
  assign clear_o         = clear_q;
  assign modwait_o       = modwait_q;
  assign err_o           = err_q;

endmodule
